// File: rtl/sd_block_responder_pkg.sv
// Shared definitions for the SD block responder: state encoding and sector geometry.
package sd_block_responder_pkg;

  localparam int unsigned SD_BLK_BYTES = 512;
  localparam int unsigned SD_IDX_W     = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_RD_FETCH,
    ST_RD_PUT,
    ST_WR_ADDR,
    ST_WR_LATCH,
    ST_WR_STORE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sd_block_responder.sv
// Serves one 512-byte SD block request at a time between the sector buffer and
// a byte-wide backing store. Blocks at or beyond img_blocks read back as zeros
// and silently discard writes.
module sd_block_responder
  import sd_block_responder_pkg::*;
#(
  parameter int unsigned ACK_DELAY = 4,
  parameter int unsigned MEM_AW    = 24
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  input  logic [31:0]       img_blocks,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              mem_ready,
  output logic              busy
);

  typedef logic [MEM_AW-1:0] maddr_t;
  localparam logic [SD_IDX_W-1:0] IDX_LAST = SD_IDX_W'(SD_BLK_BYTES - 1);

  state_e              state_q, state_d;
  logic [31:0]         lba_q, lba_d;
  logic [SD_IDX_W-1:0] idx_q, idx_d;
  logic [3:0]          dly_q, dly_d;
  logic                wr_q, wr_d;
  logic                ack_q, ack_d;
  logic [7:0]          dout_q, dout_d;
  logic [7:0]          mdout_q, mdout_d;
  logic                in_range;

  assign in_range     = (lba_q < img_blocks);
  assign mem_addr     = maddr_t'({lba_q, idx_q});
  assign sd_buff_addr = idx_q;
  assign sd_buff_dout = dout_q;
  assign mem_dout     = mdout_q;
  assign sd_ack       = ack_q;
  assign busy         = (state_q != ST_IDLE);
  assign sd_buff_wr   = (state_q == ST_RD_PUT);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lba_q   <= '0;
      idx_q   <= '0;
      dly_q   <= '0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      dout_q  <= '0;
      mdout_q <= '0;
    end else begin
      state_q <= state_d;
      lba_q   <= lba_d;
      idx_q   <= idx_d;
      dly_q   <= dly_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      mdout_q <= mdout_d;
    end
  end

  // Next-state, counter and store-handshake decode.
  always_comb begin
    state_d = state_q;
    lba_d   = lba_q;
    idx_d   = idx_q;
    dly_d   = dly_q;
    wr_d    = wr_q;
    ack_d   = ack_q;
    dout_d  = dout_q;
    mdout_d = mdout_q;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sd_rd || sd_wr) begin
          lba_d   = sd_lba;
          idx_d   = '0;
          dly_d   = 4'(ACK_DELAY);
          wr_d    = !sd_rd;
          state_d = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (dly_q <= 4'd1) begin
          dly_d   = '0;
          ack_d   = 1'b1;
          state_d = wr_q ? ST_WR_ADDR : ST_RD_FETCH;
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      ST_RD_FETCH: begin
        if (!in_range) begin
          dout_d  = '0;
          state_d = ST_RD_PUT;
        end else begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            dout_d  = mem_din;
            state_d = ST_RD_PUT;
          end
        end
      end
      ST_RD_PUT: begin
        if (idx_q == IDX_LAST) begin
          ack_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_RD_FETCH;
        end
      end
      ST_WR_ADDR: state_d = ST_WR_LATCH;
      ST_WR_LATCH: begin
        mdout_d = sd_buff_din;
        state_d = ST_WR_STORE;
      end
      ST_WR_STORE: begin
        mem_wr = in_range;
        if (!in_range || mem_ready) begin
          if (idx_q == IDX_LAST) begin
            ack_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_WR_ADDR;
          end
        end
      end
      ST_DONE: begin
        if (!sd_rd && !sd_wr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_block_responder.sv
module tb_sd_block_responder;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic [31:0] img_blocks;
  logic [23:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_dout, mem_din;
  logic        mem_ready;
  logic        busy;

  sd_block_responder #(.ACK_DELAY(4), .MEM_AW(24)) dut (
    .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .img_blocks(img_blocks),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Backing store read model: byte = addr[7:0] ^ lba[7:0].
  assign mem_din = mem_addr[7:0] ^ mem_addr[16:9];

  // Sector buffer contents and monitor state.
  logic [7:0] sbuf [512];
  logic [7:0] rdbuf [512];
  int         rdseq [512];
  logic [7:0] store [4096];
  int         stseq [4096];
  int         xfer_id = 0;
  int         strobes = 0, rd_hs = 0, wr_hs = 0, overlap = 0;
  logic       rand_mode = 1'b0;
  int         wait_cnt = 0;
  int         n_chk = 0, n_fail = 0;

  always @(posedge clk_sys) begin
    sd_buff_din <= sbuf[sd_buff_addr];
    if (sd_buff_wr) begin
      strobes++;
      rdbuf[sd_buff_addr] = sd_buff_dout;
      rdseq[sd_buff_addr] = xfer_id;
    end
    if (mem_rd && mem_ready) rd_hs++;
    if (mem_wr && mem_ready) begin
      wr_hs++;
      store[mem_addr[11:0]] = mem_dout;
      stseq[mem_addr[11:0]] = xfer_id;
    end
    if (mem_rd && mem_wr) overlap++;
  end

  // Store completion: always ready, or ready after 0-3 extra cycles.
  always @(negedge clk_sys) begin
    if (!rand_mode) mem_ready = 1'b1;
    else if (mem_ready) begin
      mem_ready = 1'b0;
      wait_cnt  = $urandom_range(0, 3);
    end else if (mem_rd || mem_wr) begin
      if (wait_cnt == 0) mem_ready = 1'b1;
      else wait_cnt--;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts edges from the current point until sd_ack is seen high.
  task automatic wait_ack(output int edges);
    edges = 0;
    do begin
      @(posedge clk_sys); #1;
      edges++;
    end while (!sd_ack && edges < 50);
  endtask

  task automatic wait_ack_low(input string name);
    int n = 0;
    while (sd_ack && n < 20000) begin
      @(posedge clk_sys); #1;
      n++;
    end
    chk({name, "_ack_fall"}, {31'd0, sd_ack}, 32'd0);
  endtask

  task automatic release_req(input string name);
    int n = 0;
    @(negedge clk_sys);
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    while (busy && n < 5) begin
      @(posedge clk_sys); #1;
      n++;
    end
    chk({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // kind: 0 = no data check, 1 = read pattern, 2 = read zeros, 3 = store contents
  typedef struct {
    logic        rd, wr, rnd;
    logic [31:0] lba, img;
    int          exp_strb, exp_rdh, exp_wrh, kind, hold;
  } vec_t;

  task automatic run_vec(input vec_t v, input string name);
    int s0, r0, w0, edges, bad;
    @(negedge clk_sys);
    xfer_id++;
    rand_mode  = v.rnd;
    img_blocks = v.img;
    sd_lba     = v.lba;
    sd_rd      = v.rd;
    sd_wr      = v.wr;
    s0 = strobes; r0 = rd_hs; w0 = wr_hs;
    wait_ack(edges);
    chk({name, "_ack_latency"}, edges, 32'd5);
    @(negedge clk_sys);
    sd_lba = v.lba ^ 32'h5;
    wait_ack_low(name);
    bad = 0;
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk_sys); #1;
      if (!busy || sd_ack) bad++;
    end
    if (v.hold > 0) chk({name, "_done_hold"}, bad, 32'd0);
    release_req(name);
    chk({name, "_strobes"}, strobes - s0, v.exp_strb);
    chk({name, "_mem_rd_hs"}, rd_hs - r0, v.exp_rdh);
    chk({name, "_mem_wr_hs"}, wr_hs - w0, v.exp_wrh);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      logic [7:0] e;
      e = 8'(i) ^ v.lba[7:0];
      case (v.kind)
        1: if (rdseq[i] != xfer_id || rdbuf[i] !== e) bad++;
        2: if (rdseq[i] != xfer_id || rdbuf[i] !== 8'h00) bad++;
        3: if (stseq[v.lba[2:0]*512 + i] != xfer_id ||
               store[v.lba[2:0]*512 + i] !== (8'hA5 ^ 8'(i))) bad++;
        default: ;
      endcase
    end
    if (v.kind != 0) chk({name, "_data"}, bad, 32'd0);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t hold_v;
    int   edges, n, s0;

    for (int i = 0; i < 512; i++) sbuf[i] = 8'hA5 ^ 8'(i);
    for (int i = 0; i < 512; i++) rdseq[i] = -1;
    for (int i = 0; i < 4096; i++) stseq[i] = -1;

    //          rd    wr    rnd   lba    img    strb rdh  wrh  kind hold
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'd3, 32'd8, 512, 512, 0,   1,   0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'd2, 32'd8, 0,   0,   512, 3,   0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'd4, 32'd4, 512, 0,   0,   2,   0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'd9, 32'd4, 0,   0,   0,   0,   0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'd1, 32'd8, 512, 512, 0,   1,   0};
    hold_v  = '{1'b1, 1'b0, 1'b0, 32'd5, 32'd8, 512, 512, 0,   1,   10};

    reset = 1'b1; sd_rd = 1'b0; sd_wr = 1'b0; sd_lba = '0; img_blocks = 32'd8;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_outputs", {sd_ack, sd_buff_wr, mem_rd, mem_wr, busy}, 32'd0);
    chk("rst_addrs", {mem_addr, sd_buff_addr}, 32'd0);
    chk("rst_data", {sd_buff_dout, mem_dout}, 32'd0);
    @(negedge clk_sys);
    reset = 1'b0;

    for (int k = 0; k < 5; k++) run_vec(vecs[k], $sformatf("vec%0d", k));
    run_vec(hold_v, "hold");

    // Reset in the middle of a read, with the request still held afterwards.
    @(negedge clk_sys);
    rand_mode = 1'b0; img_blocks = 32'd8; sd_lba = 32'd3; sd_rd = 1'b1;
    n = 0;
    do begin
      @(posedge clk_sys); #1;
      n++;
    end while (!(sd_buff_wr && sd_buff_addr == 9'd200) && n < 5000);
    chk("mid_reach_idx200", {23'd0, sd_buff_addr}, 32'd200);
    @(negedge clk_sys);
    reset = 1'b1;
    @(posedge clk_sys); #1;
    chk("mid_rst_ctrl", {sd_ack, sd_buff_wr, mem_rd, mem_wr, busy}, 32'd0);
    chk("mid_rst_addrs", {mem_addr, sd_buff_addr}, 32'd0);
    chk("mid_rst_data", {sd_buff_dout, mem_dout}, 32'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    xfer_id++;
    s0 = strobes;
    wait_ack(edges);
    chk("mid_fresh_ack_latency", edges, 32'd5);
    wait_ack_low("mid");
    chk("mid_fresh_strobes", strobes - s0, 32'd512);
    n = 0;
    for (int i = 0; i < 512; i++)
      if (rdseq[i] != xfer_id || rdbuf[i] !== (8'(i) ^ 8'h03)) n++;
    chk("mid_fresh_data", n, 32'd0);
    release_req("mid");

    chk("rd_wr_overlap", overlap, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard bound on the whole run.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sd_block_responder.md
SD_BLOCK_RESPONDER -- requirements
Module: sd_block_responder

Interface
REQ-001 Parameter ACK_DELAY, default 4: idle cycles between request detection and sd_ack assertion (range 1..15).
REQ-002 Parameter MEM_AW, default 24: byte-address width of the backing store.
REQ-003 clk_sys  in  1  sole clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 sd_lba  in  32  block number, sampled with the request.
REQ-006 sd_rd  in  1  read-block request, level, held by initiator until sd_ack seen.
REQ-007 sd_wr  in  1  write-block request, same rules as sd_rd.
REQ-008 sd_ack  out  1  high for the whole transfer.
REQ-009 sd_buff_addr  out  9  sector-buffer byte index.
REQ-010 sd_buff_dout  out  8  byte written into sector buffer.
REQ-011 sd_buff_wr  out  1  one-cycle write strobe into sector buffer.
REQ-012 sd_buff_din  in  8  sector-buffer read data, valid one cycle after sd_buff_addr.
REQ-013 img_blocks  in  32  image size in 512-byte blocks; 0 = no image.
REQ-014 mem_addr  out  MEM_AW  backing-store byte address.
REQ-015 mem_rd / mem_wr  out  1 each  store request, held until mem_ready.
REQ-016 mem_dout  out  8  store write data; mem_din  in  8  store read data.
REQ-017 mem_ready  in  1  store completion; counts in the same cycle as the request.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 States: IDLE, DELAY, RD_FETCH, RD_PUT, WR_ADDR, WR_LATCH, WR_STORE, DONE.
REQ-020 IDLE: on sd_rd or sd_wr high, latch sd_lba, clear index to 0, load delay counter, go DELAY; sd_rd wins if both high (sd_wr ignored for that transfer).
REQ-021 DELAY: count ACK_DELAY cycles, then assert sd_ack (registered) and enter RD_FETCH or WR_ADDR.
REQ-022 Block is out of range when latched lba >= img_blocks; no mem_rd/mem_wr is ever issued for it.
REQ-023 mem_addr = {lba, index[8:0]} truncated to MEM_AW bits.
REQ-024 RD_FETCH: hold mem_rd until mem_ready, capture mem_din into sd_buff_dout, go RD_PUT; out of range: load 0x00 without mem_rd, go RD_PUT next cycle.
REQ-025 RD_PUT: sd_buff_wr=1 for exactly one cycle with sd_buff_addr=index; index 511 -> DONE, else index+1 -> RD_FETCH.
REQ-026 WR_ADDR: drive sd_buff_addr=index one cycle; WR_LATCH: capture sd_buff_din into mem_dout; WR_STORE: hold mem_wr until mem_ready (out of range: skip store, one cycle); index 511 -> DONE, else index+1 -> WR_ADDR.
REQ-027 Index is 9 bits; increment after 511 never happens (DONE taken instead), no wrap into a second block.
REQ-028 DONE: deassert sd_ack; return to IDLE only after sd_rd and sd_wr both sampled low (minimum one cycle in DONE).
REQ-029 Exactly 512 sd_buff_wr pulses per read, 0 per write; exactly 512 mem_rd or mem_wr handshakes per in-range transfer.
REQ-030 mem_rd and mem_wr never high together; sd_buff_wr never high outside RD_PUT.
REQ-031 sd_lba changes after latch have no effect on the current transfer.

Reset
REQ-032 reset, at any state including mid-transfer, forces IDLE on the next edge: sd_ack, sd_buff_wr, mem_rd, mem_wr, busy = 0; sd_buff_addr, sd_buff_dout, mem_addr, mem_dout, index, counters = 0.
REQ-033 Pending request after reset release is treated as new (restarts from DELAY).

Structure
REQ-034 Shared package holds the state enum, SD_BLK_BYTES=512, SD_IDX_W=9.
REQ-035 Single module; no sub-module; delay counter and index counter inline.

Verification
REQ-036 img_blocks=8, store byte = addr[7:0]^lba[7:0], mem_ready tied 1; sd_rd, lba=3 -> sd_ack after 4+1 cycles, 512 strobes, byte at index i = i[7:0]^0x03, sd_ack low after index 511.
REQ-037 Buffer preloaded 0xA5..., sd_wr, lba=2, mem_ready random 0-3 cycle latency -> store bytes 0x400..0x5FF match buffer, 512 mem_wr handshakes, no sd_buff_wr.
REQ-038 img_blocks=4, sd_rd lba=4 -> 512 strobes of 0x00, zero mem_rd; sd_wr lba=9 -> zero mem_wr, sd_ack still asserted then dropped.
REQ-039 sd_rd and sd_wr both high, lba=1 -> read performed, no mem_wr.
REQ-040 reset pulsed at index 200 of a read -> next cycle all outputs 0, state IDLE; held sd_rd after release -> full fresh 512-byte transfer.
REQ-041 Initiator keeps sd_rd high 10 cycles after sd_ack falls -> responder stays in DONE, busy=1, no second transfer until sd_rd low.
